universal_shift_reg: RTL and testbench

- WIDTH-bit universal shift register, one D storage element per bit, with parallel load, bidirectional serial shift and hold.
- Sits directly downstream of the single-bit D flip-flop stage: it chains those storage bits into a word-level register.
- A frame counter flags when WIDTH shifts have completed since the last load or reset, so a serial-to-parallel consumer can sample q.

---
 rtl/universal_shift_reg_pkg.sv | 23 ++
 rtl/universal_shift_reg_stage.sv | 44 ++++
 rtl/universal_shift_reg.sv | 101 ++++++++++
 tb/tb_universal_shift_reg.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/universal_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encoding and
// the frame-counter step helper.
package universal_shift_reg_pkg;

    typedef logic [1:0] usr_mode_t;

    localparam usr_mode_t MODE_HOLD = 2'b00;
    localparam usr_mode_t MODE_SHR  = 2'b01;
    localparam usr_mode_t MODE_SHL  = 2'b10;
    localparam usr_mode_t MODE_LOAD = 2'b11;

    // True for either shift direction; both advance the frame counter.
    function automatic logic is_shift(input usr_mode_t m);
        logic r;
        case (m)
            MODE_SHR: r = 1'b1;
            MODE_SHL: r = 1'b1;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/universal_shift_reg_stage.sv
// One storage bit of the universal shift register: a 4:1 next-state mux,
// gated by the synchronous reset, feeding a rising-edge D flip-flop.
module usr_stage
    import universal_shift_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       shr_bit,
    input  logic       shl_bit,
    input  logic       par_bit,
    output logic       q,
    output logic       q_n
);

    usr_mode_t mode_s;
    logic      mux_s;
    logic      d_s;
    logic      q_r;

    assign mode_s = mode;

    // Next-state selection; reset forces D low so no asynchronous path exists.
    always_comb begin
        mux_s = q_r;
        case (mode_s)
            MODE_HOLD: mux_s = q_r;
            MODE_SHR:  mux_s = shr_bit;
            MODE_SHL:  mux_s = shl_bit;
            MODE_LOAD: mux_s = par_bit;
            default:   mux_s = q_r;
        endcase
        d_s = mux_s & rst_n;
    end

    // Storage bit.
    always_ff @(posedge clk) begin
        q_r <= d_s;
    end

    assign q   = q_r;
    assign q_n = ~q_r;

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register (hold / shift right / shift left / load)
// with a frame counter that pulses frame_done after every WIDTH shifts.
module universal_shift_reg
    import universal_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   mode,
    input  logic                         ser_in_r,
    input  logic                         ser_in_l,
    input  logic [WIDTH-1:0]             par_in,
    output logic [WIDTH-1:0]             q,
    output logic [WIDTH-1:0]             q_n,
    output logic                         ser_out_r,
    output logic                         ser_out_l,
    output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
    output logic                         frame_done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    usr_mode_t        mode_s;
    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] q_n_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             done_r;
    logic             done_nxt_s;

    assign mode_s = mode;

    // Bit i takes q[i+1] on a right shift and q[i-1] on a left shift;
    // the end bits take the serial inputs instead.
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        logic shr_src_s;
        logic shl_src_s;

        if (i == WIDTH - 1) begin : g_msb
            assign shr_src_s = ser_in_r;
        end else begin : g_mid_r
            assign shr_src_s = q_s[i+1];
        end

        if (i == 0) begin : g_lsb
            assign shl_src_s = ser_in_l;
        end else begin : g_mid_l
            assign shl_src_s = q_s[i-1];
        end

        usr_stage u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .mode    (mode_s),
            .shr_bit (shr_src_s),
            .shl_bit (shl_src_s),
            .par_bit (par_in[i]),
            .q       (q_s[i]),
            .q_n     (q_n_s[i])
        );
    end

    // Frame counter next state: load restarts, shifts advance and wrap at WIDTH.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        done_nxt_s = 1'b0;
        if (mode_s == MODE_LOAD) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (is_shift(mode_s)) begin
            if (cnt_r == CNT_LAST) begin
                cnt_nxt_s  = {CNT_W{1'b0}};
                done_nxt_s = 1'b1;
            end else begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter and pulse registers; reset wins over any completing shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r  <= {CNT_W{1'b0}};
            done_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    assign q          = q_s;
    assign q_n        = q_n_s;
    assign ser_out_r  = q_s[0];
    assign ser_out_l  = q_s[WIDTH-1];
    assign shift_cnt  = cnt_r;
    assign frame_done = done_r;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg at WIDTH=8.
module tb_universal_shift_reg;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [1:0]   mode;
    logic         ser_in_r;
    logic         ser_in_l;
    logic [W-1:0] par_in;
    logic [W-1:0] q;
    logic [W-1:0] q_n;
    logic         ser_out_r;
    logic         ser_out_l;
    logic [3:0]   shift_cnt;
    logic         frame_done;

    int n_cmp;
    int n_err;

    universal_shift_reg #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .ser_in_r   (ser_in_r),
        .ser_in_l   (ser_in_l),
        .par_in     (par_in),
        .q          (q),
        .q_n        (q_n),
        .ser_out_r  (ser_out_r),
        .ser_out_l  (ser_out_l),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, clock once, then settle before sampling.
    task automatic step(input logic [1:0] m, input logic sr, input logic sl,
                        input logic [W-1:0] p, input logic rn);
        mode     = m;
        ser_in_r = sr;
        ser_in_l = sl;
        par_in   = p;
        rst_n    = rn;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] shr_bits;
    logic [7:0] mixed_sl;

    initial begin
        n_cmp = 0;
        n_err = 0;
        mode = 2'b00; ser_in_r = 1'b0; ser_in_l = 1'b0; par_in = 8'h00; rst_n = 1'b0;

        // 1. reset dominates load
        step(2'b11, 1'b0, 1'b0, 8'hA5, 1'b0);
        step(2'b11, 1'b0, 1'b0, 8'hA5, 1'b0);
        chk("rst_q",    32'(q),          32'h00);
        chk("rst_qn",   32'(q_n),        32'hFF);
        chk("rst_cnt",  32'(shift_cnt),  32'h0);
        chk("rst_done", 32'(frame_done), 32'h0);

        // 2. parallel load
        step(2'b11, 1'b0, 1'b0, 8'hA5, 1'b1);
        chk("ld_q",    32'(q),         32'hA5);
        chk("ld_qn",   32'(q_n),       32'h5A);
        chk("ld_sor",  32'(ser_out_r), 32'h1);
        chk("ld_sol",  32'(ser_out_l), 32'h1);
        chk("ld_cnt",  32'(shift_cnt), 32'h0);
        step(2'b11, 1'b0, 1'b0, 8'h7E, 1'b1);
        chk("ld2_sor", 32'(ser_out_r), 32'h0);
        chk("ld2_sol", 32'(ser_out_l), 32'h0);
        // hold ignores serial and parallel inputs
        step(2'b00, 1'b1, 1'b1, 8'h11, 1'b1);
        chk("hold_q",  32'(q),         32'h7E);

        // 3. shift-right frame from zero
        step(2'b11, 1'b0, 1'b0, 8'h00, 1'b1);
        shr_bits = 8'b0100_1101;  // ser_in_r sequence 1,0,1,1,0,0,1,0 read from bit 0
        for (int k = 0; k < 8; k++) begin
            step(2'b01, shr_bits[k], 1'b0, 8'hFF, 1'b1);
            chk("shr_done", 32'(frame_done), (k == 7) ? 32'h1 : 32'h0);
            chk("shr_cnt",  32'(shift_cnt),  32'((k + 1) % 8));
        end
        chk("shr_q", 32'(q), 32'h4D);
        step(2'b00, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("shr_done_clr", 32'(frame_done), 32'h0);

        // 4. mixed directions with holds
        step(2'b11, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(2'b10, 1'b0, 1'b1, 8'h00, 1'b1);
            chk("mix_l_done", 32'(frame_done), 32'h0);
        end
        chk("mix_l_q", 32'(q), 32'h0F);
        for (int k = 0; k < 2; k++) begin
            step(2'b00, 1'b1, 1'b1, 8'hFF, 1'b1);
            chk("mix_hold_cnt", 32'(shift_cnt), 32'h4);
            chk("mix_hold_q",   32'(q),         32'h0F);
        end
        mixed_sl = 8'h00;
        for (int k = 0; k < 4; k++) begin
            step(2'b01, 1'b0, 1'b0, 8'h00, 1'b1);
            chk("mix_r_done", 32'(frame_done), (k == 3) ? 32'h1 : 32'h0);
        end
        chk("mix_r_q",   32'(q),         32'(mixed_sl));
        chk("mix_r_cnt", 32'(shift_cnt), 32'h0);

        // 4b. load after 3 shifts restarts the frame
        step(2'b11, 1'b0, 1'b0, 8'hA5, 1'b1);
        for (int k = 0; k < 3; k++) step(2'b01, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("mid_cnt3", 32'(shift_cnt), 32'h3);
        step(2'b11, 1'b0, 1'b0, 8'h3C, 1'b1);
        chk("mid_ld_cnt",  32'(shift_cnt),  32'h0);
        chk("mid_ld_done", 32'(frame_done), 32'h0);
        for (int k = 0; k < 8; k++) begin
            step(2'b01, 1'b1, 1'b0, 8'h00, 1'b1);
            chk("mid_done", 32'(frame_done), (k == 7) ? 32'h1 : 32'h0);
        end
        chk("mid_q", 32'(q), 32'hFF);

        // 5. reset after 5 shifts
        step(2'b11, 1'b0, 1'b0, 8'hC3, 1'b1);
        for (int k = 0; k < 5; k++) step(2'b10, 1'b0, 1'b1, 8'h00, 1'b1);
        chk("r5_cnt", 32'(shift_cnt), 32'h5);
        step(2'b10, 1'b0, 1'b1, 8'h00, 1'b0);
        chk("r5_q",    32'(q),          32'h00);
        chk("r5_cnt0", 32'(shift_cnt),  32'h0);
        chk("r5_done", 32'(frame_done), 32'h0);

        // 5b. reset coinciding with the 8th shift
        for (int k = 0; k < 7; k++) step(2'b01, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("r8_cnt7", 32'(shift_cnt), 32'h7);
        step(2'b01, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("r8_done", 32'(frame_done), 32'h0);
        chk("r8_cnt",  32'(shift_cnt),  32'h0);
        chk("r8_q",    32'(q),          32'h00);
        step(2'b00, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("r8_done2", 32'(frame_done), 32'h0);

        // 6. back-to-back frames, then load right after a completed frame
        step(2'b11, 1'b0, 1'b0, 8'h81, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            step(2'b01, 1'b0, 1'b0, 8'h00, 1'b1);
            chk("b2b_cnt",  32'(shift_cnt),  32'(k % 8));
            chk("b2b_done", 32'(frame_done), (k % 8 == 0) ? 32'h1 : 32'h0);
        end
        chk("b2b_q", 32'(q), 32'h00);
        step(2'b11, 1'b1, 1'b1, 8'h5A, 1'b1);
        chk("pf_ld_done", 32'(frame_done), 32'h0);
        chk("pf_ld_cnt",  32'(shift_cnt),  32'h0);
        chk("pf_ld_q",    32'(q),          32'h5A);
        step(2'b10, 1'b0, 1'b1, 8'h00, 1'b1);
        chk("shl_q",   32'(q),         32'hB5);
        chk("shl_sol", 32'(ser_out_l), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
